bcd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `bcd` double-dabble converter (12-bit binary in, 16-bit BCD out) among up to `N_REQ` requesters. It sits between client blocks (display drivers, UART formatters) and the single converter instance. It latches the winning operand, pulses the converter's `en`, waits for `rdy`, and returns the BCD result with a per-requester completion pulse.

---
 rtl/bcd_arbiter_if.sv | 31 +++
 rtl/bcd_arbiter.sv | 143 ++++++++++++++
 tb/tb_bcd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_arbiter_if.sv
// bcd_arbiter_if: client-side request/result bundle and converter-side
// start/ready handshake shared by the bcd arbiter.
interface bcd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int BIN_W = 12,
  parameter int BCD_W = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic [BCD_W-1:0]       bcd_out;
  logic                   busy;
  logic                   conv_en;
  logic [BIN_W-1:0]       conv_bin;
  logic [BCD_W-1:0]       conv_bcd;
  logic                   conv_rdy;

  modport slave (
    input  req, bin_in, conv_bcd, conv_rdy,
    output gnt, done, err, bcd_out, busy,
    output conv_en, conv_bin
  );

  modport master (
    output req, bin_in, conv_bcd, conv_rdy,
    input  gnt, done, err, bcd_out, busy,
    input  conv_en, conv_bin
  );
endinterface

// File: rtl/bcd_arbiter.sv
// bcd_arbiter: round-robin sequencer sharing one bcd converter.
// Optional WAIT abort is built when BCD_ARB_TIMEOUT_EN is defined.
module bcd_arbiter #(
  parameter int N_REQ          = 4,
  parameter int BIN_W          = 12,
  parameter int BCD_W          = 16,
  parameter int TIMEOUT_CYCLES = 127
) (
  input logic          clk,
  input logic          rst_n,
  bcd_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic             win_vld;
  logic             tmo;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic             err_q;

  // nearest active request after ptr wins, wrapping around
  always_comb begin : rr
    int j;
    j       = 0;
    win     = ptr;
    win_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (bus.req[j]) begin
        win     = IW'(j);
        win_vld = 1'b1;
      end
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // WAIT cycle counter, restarted in ARM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ARM) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (state == WAIT) && !bus.conv_rdy &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (win_vld) nxt = LAUNCH;
      LAUNCH:  nxt = ARM;
      ARM:     nxt = WAIT;
      WAIT:    if (bus.conv_rdy || tmo) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // owner, operand, result and rotation pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      ptr   <= IW'(N_REQ - 1);
      bin_q <= '0;
      bcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            idx   <= win;
            bin_q <= bus.bin_in[int'(win)*BIN_W +: BIN_W];
            err_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.conv_rdy) begin
            bcd_q <= bus.conv_bcd;
            err_q <= 1'b0;
          end else if (tmo) begin
            bcd_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP:    ptr <= idx;
        default: ;
      endcase
    end
  end

  // outputs decoded from state; conv_en drops with async reset
  always_comb begin
    bus.gnt     = '0;
    bus.done    = '0;
    bus.conv_en = 1'b0;
    bus.busy    = (state != IDLE);
    bus.err     = err_q && (state == RESP);
    bus.bcd_out = bcd_q;
    bus.conv_bin = bin_q;
    unique case (state)
      LAUNCH: begin
        bus.gnt[idx] = 1'b1;
        bus.conv_en  = 1'b1;
      end
      ARM, WAIT: bus.gnt[idx] = 1'b1;
      RESP:      bus.done[idx] = 1'b1;
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_bcd_arbiter.sv
// tb_bcd_arbiter: random batches against a round-robin model,
// with a latency-programmable converter model and scoreboard.
module tb_bcd_arbiter;
  localparam int N  = 4;
  localparam int BW = 12;
  localparam int DW = 16;
  localparam int TO = 127;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd_arbiter_if #(
    .N_REQ(N), .BIN_W(BW), .BCD_W(DW)
  ) bus ();

  bcd_arbiter #(
    .N_REQ(N), .BIN_W(BW), .BCD_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int        idx;
    int        op;
    logic [15:0] bcd;
    logic      err;
  } exp_t;

  exp_t exp_q[$];

  int m_ptr;
  int rounds[N];
  int ops[N][6];
  bit tmo_mode;

  task automatic chk(input string nm,
                     input longint act,
                     input longint want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, want);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // converter model: starts one cycle after sampling conv_en,
  // leaves rdy high until the next start
  logic           en_d    = 1'b0;
  logic           rdy     = 1'b0;
  logic           stuck   = 1'b0;
  int             cnt_c   = 0;
  int             conv_lat = 64;
  int             lat_used = 0;
  logic [BW-1:0]  bin_cap = '0;
  logic [DW-1:0]  bcd_val = '0;

  always @(posedge clk) begin
    en_d <= bus.conv_en;
    if (bus.conv_en) begin
      bin_cap  <= bus.conv_bin;
      lat_used <= conv_lat;
    end
    if (en_d) begin
      cnt_c   <= lat_used;
      rdy     <= 1'b0;
      bcd_val <= to_bcd(int'(bin_cap));
    end else if (cnt_c == 1) begin
      if (!stuck) rdy <= 1'b1;
      cnt_c <= 0;
    end else if (cnt_c > 1) begin
      cnt_c <= cnt_c - 1;
    end
  end

  assign bus.conv_rdy = rdy;
  assign bus.conv_bcd = rdy ? bcd_val : 16'hDEAD;

  // scoreboard monitor
  int en_cyc = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    if (rst_n) begin
      if (bus.busy)
        chk("gnt_onehot", $countones(bus.gnt) <= 1, 1);
      if (bus.conv_en) begin
        en_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL launch: got conv_en expected none");
        end else begin
          chk("gnt", bus.gnt, 1 << exp_q[0].idx);
          chk("conv_bin", bus.conv_bin, exp_q[0].op);
        end
      end
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL done: got %0h expected none",
                   bus.done);
        end else begin
          e   = exp_q.pop_front();
          lat = e.err ? TO + 2 : lat_used + 3;
          chk("done", bus.done, 1 << e.idx);
          chk("bcd_out", bus.bcd_out, e.bcd);
          chk("err", bus.err, e.err);
          chk("gnt_resp", bus.gnt, 0);
          chk("latency", cyc - en_cyc, lat);
        end
      end
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) rounds[i] = 0;
    tmo_mode = 1'b0;
  endtask

  // model order by rotation, then act as the requesters
  task automatic run_batch();
    int rem[N];
    int srv[N];
    int sent[N];
    int p;
    int j;
    bit found;
    exp_t e;
    logic [N-1:0]    req_l;
    logic [N*BW-1:0] bin_l;
    int n;
    rem = rounds;
    for (int i = 0; i < N; i++) srv[i] = 0;
    p = m_ptr;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (p + k) % N;
        if (!found && rem[j] > 0) begin
          e.idx = j;
          e.op  = ops[j][srv[j]];
          e.bcd = tmo_mode ? 16'h0 : to_bcd(e.op);
          e.err = tmo_mode;
          exp_q.push_back(e);
          rem[j]--;
          srv[j]++;
          p = j;
          found = 1'b1;
        end
      end
    end
    m_ptr = p;
    @(negedge clk);
    req_l = '0;
    bin_l = '0;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      req_l[i] = rounds[i] > 0;
      bin_l[i*BW +: BW] = BW'(ops[i][0]);
    end
    bus.req    = req_l;
    bus.bin_in = bin_l;
    n = 0;
    while (req_l != '0 && n < 5000) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++) begin
        if (bus.done[i] && req_l[i]) begin
          sent[i]++;
          if (sent[i] < rounds[i])
            bin_l[i*BW +: BW] = BW'(ops[i][sent[i]]);
          else
            req_l[i] = 1'b0;
        end
      end
      bus.req    = req_l;
      bus.bin_in = bin_l;
    end
    if (req_l != '0) begin
      n_vec++;
      n_bad++;
      $display("FAIL batch: got pending %0h expected 0",
               req_l);
    end
    repeat (2) @(negedge clk);
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_ptr = N - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int m;
    bus.req    = '0;
    bus.bin_in = '0;
    m_ptr      = N - 1;
    clear_cfg();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_bcd", bus.bcd_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.conv_en, 0);
    chk("rst_bin", bus.conv_bin, 0);
    rst_n = 1'b1;

    conv_lat = 64;
    clear_cfg();
    rounds[0] = 1;
    ops[0][0] = 0;
    run_batch();

    conv_lat = 9;
    clear_cfg();
    rounds[1] = 1;
    ops[1][0] = 4095;
    run_batch();

    @(negedge clk);
    do_reset();
    conv_lat = 5;
    clear_cfg();
    for (int i = 0; i < N; i++) rounds[i] = 1;
    ops[0][0] = 1;
    ops[1][0] = 10;
    ops[2][0] = 100;
    ops[3][0] = 1000;
    run_batch();

    conv_lat = 3;
    clear_cfg();
    rounds[0] = 4;
    rounds[2] = 4;
    for (int r = 0; r < 4; r++) begin
      ops[0][r] = int'($urandom_range(0, 4095));
      ops[2][r] = int'($urandom_range(0, 4095));
    end
    run_batch();

    repeat (25) begin
      conv_lat = int'($urandom_range(1, 12));
      clear_cfg();
      m = int'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (m[i]) rounds[i] = int'($urandom_range(1, 3));
        for (int r = 0; r < 6; r++)
          ops[i][r] = int'($urandom_range(0, 4095));
      end
      run_batch();
    end

    stuck    = 1'b1;
    conv_lat = 3;
    clear_cfg();
    ops[1][0] = int'($urandom_range(0, 4095));
`ifdef BCD_ARB_TIMEOUT_EN
    rounds[1] = 1;
    tmo_mode  = 1'b1;
    run_batch();
`else
    begin
      exp_t e;
      e.idx = 1;
      e.op  = ops[1][0];
      e.bcd = to_bcd(e.op);
      e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req    = 4'b0010;
    bus.bin_in = '0;
    bus.bin_in[BW +: BW] = BW'(ops[1][0]);
    repeat (300) @(negedge clk);
    chk("stuck_busy", bus.busy, 1);
    chk("stuck_gnt", bus.gnt, 2);
    chk("stuck_done", bus.done, 0);
    bus.req = '0;
    do_reset();
`endif
    stuck = 1'b0;

    conv_lat = 64;
    clear_cfg();
    ops[0][0] = int'($urandom_range(0, 4095));
    ops[2][0] = int'($urandom_range(0, 4095));
    begin
      exp_t e;
      e.idx = 2;
      e.op  = ops[2][0];
      e.bcd = to_bcd(e.op);
      e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req    = 4'b0100;
    bus.bin_in = '0;
    bus.bin_in[2*BW +: BW] = BW'(ops[2][0]);
    repeat (10) @(negedge clk);
    bus.req = 4'b0101;
    bus.bin_in[0 +: BW] = BW'(ops[0][0]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", bus.gnt, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_en", bus.conv_en, 0);
    chk("arst_done", bus.done, 0);
    exp_q.delete();
    m_ptr = N - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rounds[0] = 1;
    rounds[2] = 1;
    run_batch();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
